// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for an RV32I core: sequences fetch/decode/execute/memory/writeback,
// counts retired instructions, and traps on illegal class encodings or memory wait timeouts.
module multicycle_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             R,
  input  logic             I,
  input  logic             L,
  input  logic             Jr,
  input  logic             S,
  input  logic             Sb,
  input  logic             aui,
  input  logic             lui,
  input  logic             J,
  input  logic             branch_taken,
  output logic             instr_req,
  input  logic             instr_ready,
  output logic             ir_we,
  output logic             data_req,
  output logic             data_we,
  input  logic             data_ready,
  output logic             alu_en,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             illegal,
  output logic             timeout,
  output logic [2:0]       state
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] TRAP   = 3'd5;

  localparam int T_R = 0, T_I = 1, T_L = 2, T_JR = 3, T_S = 4, T_SB = 5, T_AUI = 6, T_LUI = 7, T_J = 8;

  logic [2:0]       state_q, state_d;
  logic [8:0]       type_q, type_d;
  logic [TO_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;

  logic [8:0] flags;
  logic       flags_onehot;
  logic       wait_expired;

  assign flags        = {J, lui, aui, Sb, S, Jr, L, I, R};
  assign flags_onehot = (flags != 9'd0) && ((flags & (flags - 9'd1)) == 9'd0);
  // The cycle that would bring the counter up to TIMEOUT is the last one allowed without ready.
  assign wait_expired = (TIMEOUT != 0) && (wait_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    instr_req   = 1'b0;
    ir_we       = 1'b0;
    data_req    = 1'b0;
    data_we     = 1'b0;
    alu_en      = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = 2'd0;
    pc_we       = 1'b0;
    pc_sel      = 2'd0;
    retire      = 1'b0;
    state_d     = state_q;
    type_d      = type_q;
    wait_d      = wait_q;
    illegal_d   = illegal_q;
    timeout_d   = timeout_q;
    if (rst_n) begin
      case (state_q)
        FETCH: begin
          instr_req = 1'b1;
          if (instr_ready) begin
            ir_we   = 1'b1;
            state_d = DECODE;
          end else if (wait_expired) begin
            timeout_d = 1'b1;
            state_d   = TRAP;
          end else begin
            wait_d = wait_q + TO_W'(1);
          end
        end
        DECODE: begin
          type_d = flags;
          if (flags_onehot) begin
            state_d = EXEC;
          end else begin
            illegal_d = 1'b1;
            state_d   = TRAP;
          end
        end
        EXEC: begin
          alu_en    = 1'b1;
          alu_src_a = type_q[T_AUI];
          alu_src_b = !(type_q[T_R] || type_q[T_SB]);
          state_d   = (type_q[T_L] || type_q[T_S]) ? MEM : WB;
        end
        MEM: begin
          data_req = 1'b1;
          data_we  = type_q[T_S];
          if (data_ready) begin
            if (type_q[T_S]) begin
              pc_we   = 1'b1;
              retire  = 1'b1;
              state_d = FETCH;
            end else begin
              state_d = WB;
            end
          end else if (wait_expired) begin
            timeout_d = 1'b1;
            state_d   = TRAP;
          end else begin
            wait_d = wait_q + TO_W'(1);
          end
        end
        WB: begin
          reg_we = !type_q[T_SB];
          pc_we  = 1'b1;
          retire = 1'b1;
          if (type_q[T_J] || (type_q[T_SB] && branch_taken)) begin
            pc_sel = 2'd1;
          end else if (type_q[T_JR]) begin
            pc_sel = 2'd2;
          end
          if (type_q[T_L]) begin
            wb_sel = 2'd1;
          end else if (type_q[T_J] || type_q[T_JR]) begin
            wb_sel = 2'd2;
          end else if (type_q[T_LUI]) begin
            wb_sel = 2'd3;
          end
          state_d = FETCH;
        end
        TRAP: begin
          state_d = TRAP;
        end
        default: begin
          state_d = TRAP;
        end
      endcase
      if (state_d != state_q) begin
        wait_d = '0;
      end
    end
  end

  assign instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      type_q    <= '0;
      wait_q    <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: builds each instruction's expected per-cycle output trace from its
// class and memory delays, and compares the DUT against that trace on every cycle.
module tb_multicycle_ctrl;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int TO_W    = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [8:0] flags = '0;
  logic branch_taken = 1'b0, instr_ready = 1'b0, data_ready = 1'b0;
  logic instr_req, ir_we, data_req, data_we, alu_en, alu_src_a, alu_src_b, reg_we;
  logic pc_we, retire, illegal, timeout;
  logic [1:0] wb_sel, pc_sel;
  logic [2:0] state;
  logic [CNT_W-1:0] instret;

  multicycle_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .R(flags[0]), .I(flags[1]), .L(flags[2]), .Jr(flags[3]), .S(flags[4]),
    .Sb(flags[5]), .aui(flags[6]), .lui(flags[7]), .J(flags[8]),
    .branch_taken(branch_taken),
    .instr_req(instr_req), .instr_ready(instr_ready), .ir_we(ir_we),
    .data_req(data_req), .data_we(data_we), .data_ready(data_ready),
    .alu_en(alu_en), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .reg_we(reg_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
    .retire(retire), .instret(instret), .illegal(illegal), .timeout(timeout),
    .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [22:0] exp_q[$];
  string name_q[$];
  logic [CNT_W-1:0] instret_m = '0;
  logic illegal_m = 1'b0, timeout_m = 1'b0;

  function automatic logic [22:0] dut_vec();
    return {state, instr_req, ir_we, data_req, data_we, alu_en, alu_src_a, alu_src_b, reg_we,
            wb_sel, pc_we, pc_sel, retire, illegal, timeout, instret};
  endfunction

  // ctl = {instr_req, ir_we, data_req, data_we, alu_en, alu_src_a, alu_src_b, reg_we}
  function automatic logic [22:0] mk(input logic [2:0] st, input logic [7:0] ctl,
                                     input logic [1:0] wbs, input logic pcwe,
                                     input logic [1:0] pcs, input logic ret);
    return {st, ctl, wbs, pcwe, pcs, ret, illegal_m, timeout_m, instret_m};
  endfunction

  logic [22:0] cmp_exp;
  string cmp_name;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cmp_exp  = exp_q.pop_front();
      cmp_name = name_q.pop_front();
      checks++;
      if (dut_vec() !== cmp_exp) begin
        failures++;
        $display("FAIL %s cycle=%0d got=%h expected=%h", cmp_name, cyc, dut_vec(), cmp_exp);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step(input logic [22:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic noise();
    flags        = 9'($urandom);
    branch_taken = 1'($urandom);
    instr_ready  = 1'($urandom);
    data_ready   = 1'($urandom);
  endtask

  task automatic chk(input string n, input int got, input int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", n, got, expv);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_outputs_zero", int'(dut_vec()), 0);
    @(posedge clk);
    #1;
    instret_m = '0;
    illegal_m = 1'b0;
    timeout_m = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic trap_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      noise();
      step(mk(3'd5, 8'd0, 2'd0, 1'b0, 2'd0, 1'b0), "trap");
    end
  endtask

  // One instruction: fdel/mdel are the number of cycles ready stays low before it rises.
  task automatic run_instr(input logic [8:0] df, input int fdel, input int mdel, input logic bt,
                           output int ncyc, output logic trapped);
    int c0;
    logic isr, isl, isjr, iss, issb, isaui, islui, isj;
    logic [7:0] ctl;
    logic [1:0] wbs, pcs;
    c0 = cyc;
    trapped = 1'b0;
    {isj, islui, isaui, issb, iss, isjr, isl, isr} = {df[8:2], df[0]};
    for (int k = 0; k < fdel && k < TIMEOUT; k++) begin
      noise();
      instr_ready = 1'b0;
      step(mk(3'd0, 8'b1000_0000, 2'd0, 1'b0, 2'd0, 1'b0), "fetch_wait");
    end
    if (fdel >= TIMEOUT) begin
      timeout_m = 1'b1;
      trapped = 1'b1;
    end else begin
      noise();
      instr_ready = 1'b1;
      step(mk(3'd0, 8'b1100_0000, 2'd0, 1'b0, 2'd0, 1'b0), "fetch_accept");
      noise();
      flags = df;
      step(mk(3'd1, 8'd0, 2'd0, 1'b0, 2'd0, 1'b0), "decode");
      if (!$onehot(df)) begin
        illegal_m = 1'b1;
        trapped = 1'b1;
      end else begin
        noise();
        step(mk(3'd2, {4'b0000, 1'b1, isaui, !(isr || issb), 1'b0}, 2'd0, 1'b0, 2'd0, 1'b0), "exec");
        if (isl || iss) begin
          ctl = {2'b00, 1'b1, iss, 4'b0000};
          for (int k = 0; k < mdel && k < TIMEOUT; k++) begin
            noise();
            data_ready = 1'b0;
            step(mk(3'd3, ctl, 2'd0, 1'b0, 2'd0, 1'b0), "mem_wait");
          end
          if (mdel >= TIMEOUT) begin
            timeout_m = 1'b1;
            trapped = 1'b1;
          end else begin
            noise();
            data_ready = 1'b1;
            if (iss) begin
              step(mk(3'd3, ctl, 2'd0, 1'b1, 2'd0, 1'b1), "mem_store");
              instret_m = instret_m + 1'b1;
            end else begin
              step(mk(3'd3, ctl, 2'd0, 1'b0, 2'd0, 1'b0), "mem_load");
            end
          end
        end
        if (!trapped && !iss) begin
          noise();
          branch_taken = bt;
          pcs = (isj || (issb && bt)) ? 2'd1 : (isjr ? 2'd2 : 2'd0);
          wbs = isl ? 2'd1 : ((isj || isjr) ? 2'd2 : (islui ? 2'd3 : 2'd0));
          step(mk(3'd4, {7'd0, !issb}, wbs, 1'b1, pcs, 1'b1), "writeback");
          instret_m = instret_m + 1'b1;
        end
      end
    end
    ncyc = cyc - c0;
  endtask

  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 10) return 0;
    if (r < 19) return int'($urandom_range(1, 3));
    return TIMEOUT;
  endfunction

  initial begin
    int nc;
    logic tr;
    logic [8:0] df;

    do_reset();
    run_instr(9'b0_0000_0001, 0, 0, 1'b0, nc, tr);
    chk("r_latency", nc, 4);
    chk("r_instret", int'(instret), 1);
    run_instr(9'b0_0000_0100, 0, 3, 1'b0, nc, tr);
    chk("load_latency_mem3", nc, 8);

    do_reset();
    run_instr(9'b0_0001_0000, 0, 0, 1'b0, nc, tr);
    chk("store_latency", nc, 4);
    run_instr(9'b0_0010_0000, 0, 0, 1'b1, nc, tr);
    run_instr(9'b1_0000_0000, 0, 0, 1'b0, nc, tr);
    chk("s_sb_j_instret", int'(instret), 3);

    do_reset();
    run_instr(9'b0_0000_0000, 0, 0, 1'b0, nc, tr);
    trap_cycles(3);
    chk("illegal_zero_state", int'(state), 5);
    chk("illegal_zero_flag", int'(illegal), 1);
    do_reset();
    run_instr(9'b0_0000_0011, 0, 0, 1'b0, nc, tr);
    trap_cycles(3);
    chk("illegal_multi_flag", int'(illegal), 1);

    do_reset();
    run_instr(9'b0_0000_0001, TIMEOUT, 0, 1'b0, nc, tr);
    trap_cycles(2);
    chk("fetch_timeout_flag", int'(timeout), 1);
    chk("fetch_timeout_state", int'(state), 5);
    chk("fetch_timeout_req", int'(instr_req), 0);
    do_reset();
    run_instr(9'b0_0000_0001, TIMEOUT - 1, 0, 1'b0, nc, tr);
    chk("ready_at_limit_latency", nc, 7);
    chk("ready_at_limit_no_timeout", int'(timeout), 0);
    run_instr(9'b0_0000_0100, 0, TIMEOUT, 1'b0, nc, tr);
    trap_cycles(2);
    chk("mem_timeout_flag", int'(timeout), 1);

    // Asynchronous reset while a load is waiting in MEM.
    do_reset();
    instr_ready = 1'b1;
    step(mk(3'd0, 8'b1100_0000, 2'd0, 1'b0, 2'd0, 1'b0), "fetch_accept");
    flags = 9'b0_0000_0100;
    step(mk(3'd1, 8'd0, 2'd0, 1'b0, 2'd0, 1'b0), "decode");
    step(mk(3'd2, 8'b0000_1010, 2'd0, 1'b0, 2'd0, 1'b0), "exec");
    data_ready = 1'b0;
    step(mk(3'd3, 8'b0010_0000, 2'd0, 1'b0, 2'd0, 1'b0), "mem_wait");
    chk("pre_reset_data_req", int'(data_req), 1);
    #1;
    do_reset();
    run_instr(9'b0_1000_0000, 0, 0, 1'b0, nc, tr);
    chk("resume_after_reset_instret", int'(instret), 1);

    do_reset();
    for (int k = 0; k < 16; k++) run_instr(9'b0_0000_0010, 0, 0, 1'b0, nc, tr);
    chk("instret_wrap", int'(instret), 0);

    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 19) == 0) df = 9'($urandom);
      else df = 9'(1 << $urandom_range(0, 8));
      run_instr(df, pick_delay(), pick_delay(), 1'($urandom), nc, tr);
      if (tr) begin
        trap_cycles(2);
        do_reset();
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
